// File: rtl/muldiv_sequencer_if.sv
// Execute-stage handshake bundle between the pipeline and the iterative mul/div unit.
// Slave modport is the unit itself; master modport is the pipeline side.
// Carries the op request, the kill, the stall request and the registered result.
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start_e;
  logic [1:0]      op_e;
  logic [XLEN-1:0] a_e;
  logic [XLEN-1:0] b_e;
  logic [4:0]      rd_e;
  logic            flush_e;
  logic            busy;
  logic            valid_m;
  logic [XLEN-1:0] result_m;
  logic [4:0]      rd_m;

  modport master (
    output start_e, op_e, a_e, b_e, rd_e, flush_e,
    input  busy, valid_m, result_m, rd_m
  );

  modport slave (
    input  start_e, op_e, a_e, b_e, rd_e, flush_e,
    output busy, valid_m, result_m, rd_m
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MUL/MULHU/DIVU/REMU unit: one shift-add or restoring-divide step per cycle.
// Latency: XLEN+1 cycles from start to the valid_m pulse; divide-by-zero takes 1 cycle.
// Backpressure: busy (combinational) stalls the pipeline until the DONE cycle; flush_e kills the op.
// Optional feature: define MULDIV_EARLY_OUT_EN to end multiplies once the remaining multiplier bits are zero.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               arst_n,
  muldiv_sequencer_if.slave  mif
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [4:0]        rd_lat_q, rd_lat_d;
  logic [CW-1:0]     count_q, count_d;
  // acc: product for multiplies, partial remainder (low XLEN+1 bits) for divides
  logic [2*XLEN-1:0] acc_q, acc_d;
  // mcand: shifting multiplicand for multiplies, static divisor for divides
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  // mplier: multiplier shifting out LSB first, or dividend turning into quotient
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_m_q, rd_m_d;
  logic              valid_q, valid_d;

  logic              is_div;
  logic [2*XLEN-1:0] mul_acc;
  logic [XLEN-1:0]   mul_mplier;
  logic [XLEN:0]     div_shift;
  logic [XLEN+1:0]   div_diff;
  logic              div_ok;
  logic [XLEN:0]     div_rem;
  logic [2*XLEN-1:0] step_acc;
  logic [2*XLEN-1:0] step_mcand;
  logic [XLEN-1:0]   step_mplier;
  logic [XLEN-1:0]   step_res;
  logic              early_done;

  assign is_div = op_q[1];

  // One datapath iteration computed from the current registers
  always_comb begin
    mul_acc     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mul_mplier  = mplier_q >> 1;
    div_shift   = {acc_q[XLEN-1:0], mplier_q[XLEN-1]};
    div_diff    = {1'b0, div_shift} - {2'b00, mcand_q[XLEN-1:0]};
    div_ok      = ~div_diff[XLEN+1];
    div_rem     = div_ok ? div_diff[XLEN:0] : div_shift;
    step_acc    = is_div ? {{(XLEN-1){1'b0}}, div_rem} : mul_acc;
    step_mcand  = is_div ? mcand_q : (mcand_q << 1);
    step_mplier = is_div ? {mplier_q[XLEN-2:0], div_ok} : mul_mplier;
    unique case (op_q)
      2'b00:   step_res = step_acc[XLEN-1:0];
      2'b01:   step_res = step_acc[2*XLEN-1:XLEN];
      2'b10:   step_res = step_mplier;
      default: step_res = step_acc[XLEN-1:0];
    endcase
  end

`ifdef MULDIV_EARLY_OUT_EN
  // Multiplier exhausted after this step: no further adds can change the product
  assign early_done = ~is_div & (mul_mplier == '0);
`else
  assign early_done = 1'b0;
`endif

  assign mif.busy = ((state_q == S_IDLE) & mif.start_e & ~mif.flush_e) | (state_q == S_RUN);
  assign mif.valid_m  = valid_q;
  assign mif.result_m = result_q;
  assign mif.rd_m     = rd_m_q;

  // Next-state and register-load decisions
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_lat_d = rd_lat_q;
    count_d  = count_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
    rd_m_d   = rd_m_q;
    valid_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mif.start_e && !mif.flush_e) begin
          op_d     = mif.op_e;
          rd_lat_d = mif.rd_e;
          count_d  = CW'(XLEN);
          acc_d    = '0;
          mcand_d  = {{XLEN{1'b0}}, (mif.op_e[1] ? mif.b_e : mif.a_e)};
          mplier_d = mif.op_e[1] ? mif.a_e : mif.b_e;
          if (mif.op_e[1] && (mif.b_e == '0)) begin
            // Divide by zero resolves immediately: quotient all ones, remainder = dividend
            state_d  = S_DONE;
            valid_d  = 1'b1;
            result_d = mif.op_e[0] ? mif.a_e : '1;
            rd_m_d   = mif.rd_e;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (mif.flush_e) begin
          state_d = S_IDLE;
        end else begin
          acc_d    = step_acc;
          mcand_d  = step_mcand;
          mplier_d = step_mplier;
          count_d  = count_q - CW'(1);
          if ((count_q == CW'(1)) || early_done) begin
            state_d  = S_DONE;
            valid_d  = 1'b1;
            result_d = step_res;
            rd_m_d   = rd_lat_q;
          end
        end
      end
      S_DONE: begin
        // The held instruction leaves execute at the end of this cycle
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rd_lat_q <= '0;
      count_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      rd_m_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_lat_q <= rd_lat_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
      rd_m_q   <= rd_m_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, results, divide-by-zero, flush and reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Cycle 0 is the cycle in which start_e is first presented.
module tb_muldiv_sequencer;

  localparam int XLEN = 32;

  logic clk;
  logic arst_n;
  int   n_checks;
  int   n_errors;

  muldiv_sequencer_if #(.XLEN(XLEN)) mif ();

  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .mif    (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Expected cycle of the valid_m pulse for a multiply with multiplier b
  function automatic int mul_lat(input logic [31:0] b);
    int iters;
`ifdef MULDIV_EARLY_OUT_EN
    iters = 1;
    for (int i = 0; i < 32; i++) if (b[i]) iters = i + 1;
`else
    iters = 32;
`endif
    return iters + 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op (held through DONE) and check latency, busy span, result and rd
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp_res, input int exp_vcyc);
    int          vcyc;
    int          bcnt;
    logic [31:0] res;
    logic [4:0]  rdo;
    vcyc = -1;
    bcnt = 0;
    res  = '0;
    rdo  = '0;
    mif.start_e = 1'b1;
    mif.op_e    = op;
    mif.a_e     = a;
    mif.b_e     = b;
    mif.rd_e    = rd;
    mif.flush_e = 1'b0;
    for (int c = 0; c < 60 && vcyc < 0; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check_val({tag, "_busy0"}, 32'(mif.busy), 32'd1);
        check_val({tag, "_vld0"}, 32'(mif.valid_m), 32'd0);
      end
      if (mif.busy) bcnt++;
      if (mif.valid_m) begin
        vcyc = c;
        res  = mif.result_m;
        rdo  = mif.rd_m;
      end
      step();
    end
    mif.start_e = 1'b0;
    check_val({tag, "_lat"}, 32'(vcyc), 32'(exp_vcyc));
    check_val({tag, "_busycnt"}, 32'(bcnt), 32'(exp_vcyc));
    check_val({tag, "_res"}, res, exp_res);
    check_val({tag, "_rd"}, 32'(rdo), 32'(rd));
  endtask

  initial begin
    int          vcnt;
    logic [31:0] prev_res;
    logic [4:0]  prev_rd;
    n_checks = 0;
    n_errors = 0;
    arst_n      = 1'b0;
    mif.start_e = 1'b0;
    mif.op_e    = 2'b00;
    mif.a_e     = '0;
    mif.b_e     = '0;
    mif.rd_e    = '0;
    mif.flush_e = 1'b0;

    repeat (2) step();
    @(negedge clk);
    check_val("rst_busy", 32'(mif.busy), 32'd0);
    check_val("rst_vld", 32'(mif.valid_m), 32'd0);
    check_val("rst_res", mif.result_m, 32'd0);
    check_val("rst_rd", 32'(mif.rd_m), 32'd0);
    step();
    arst_n = 1'b1;
    step();

    do_op("mul7x6", 2'b00, 32'd7, 32'd6, 5'd5, 32'd42, mul_lat(32'd6));
    // valid_m is a single-cycle pulse
    @(negedge clk);
    check_val("mul7x6_pulse", 32'(mif.valid_m), 32'd0);
    check_val("mul7x6_hold", mif.result_m, 32'd42);
    step();

    do_op("mulhu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 32'hFFFF_FFFE, mul_lat(32'hFFFF_FFFF));
    do_op("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'h0000_0001, mul_lat(32'hFFFF_FFFF));
    // Back-to-back divides: REMU starts in the cycle right after DIVU's valid_m
    do_op("divu100_7", 2'b10, 32'd100, 32'd7, 5'd11, 32'd14, 33);
    do_op("remu100_7", 2'b11, 32'd100, 32'd7, 5'd12, 32'd2, 33);
    do_op("divu_z", 2'b10, 32'h1234, 32'd0, 5'd13, 32'hFFFF_FFFF, 1);
    do_op("remu_z", 2'b11, 32'h1234, 32'd0, 5'd14, 32'h0000_1234, 1);
    do_op("mulhu_big", 2'b01, 32'h8000_0000, 32'd6, 5'd3, 32'h0000_0003, mul_lat(32'd6));

    // Flush mid-divide at cycle 10
    step();
    prev_res = mif.result_m;
    prev_rd  = mif.rd_m;
    mif.start_e = 1'b1;
    mif.op_e    = 2'b10;
    mif.a_e     = 32'd1000;
    mif.b_e     = 32'd3;
    mif.rd_e    = 5'd20;
    repeat (10) step();
    mif.flush_e = 1'b1;
    step();
    mif.flush_e = 1'b0;
    mif.start_e = 1'b0;
    @(negedge clk);
    check_val("flush_busy", 32'(mif.busy), 32'd0);
    vcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mif.valid_m) vcnt++;
    end
    check_val("flush_novld", 32'(vcnt), 32'd0);
    check_val("flush_res", mif.result_m, prev_res);
    check_val("flush_rd", 32'(mif.rd_m), 32'(prev_rd));

    // start_e together with flush_e in IDLE: nothing accepted
    step();
    mif.start_e = 1'b1;
    mif.flush_e = 1'b1;
    mif.op_e    = 2'b10;
    mif.a_e     = 32'd50;
    mif.b_e     = 32'd0;
    mif.rd_e    = 5'd21;
    @(negedge clk);
    check_val("sflush_busy", 32'(mif.busy), 32'd0);
    step();
    mif.start_e = 1'b0;
    mif.flush_e = 1'b0;
    vcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mif.valid_m || mif.busy) vcnt++;
    end
    check_val("sflush_idle", 32'(vcnt), 32'd0);
    check_val("sflush_res", mif.result_m, prev_res);
    check_val("sflush_rd", 32'(mif.rd_m), 32'(prev_rd));

    // Reset asserted in cycle 15 of a MUL
    step();
    mif.start_e = 1'b1;
    mif.op_e    = 2'b00;
    mif.a_e     = 32'd123;
    mif.b_e     = 32'hFFFF_FFFF;
    mif.rd_e    = 5'd22;
    repeat (15) step();
    arst_n      = 1'b0;
    mif.start_e = 1'b0;
    @(negedge clk);
    check_val("mrst_busy", 32'(mif.busy), 32'd0);
    check_val("mrst_vld", 32'(mif.valid_m), 32'd0);
    check_val("mrst_res", mif.result_m, 32'd0);
    check_val("mrst_rd", 32'(mif.rd_m), 32'd0);
    step();
    arst_n = 1'b1;
    step();
    do_op("mul3x3", 2'b00, 32'd3, 32'd3, 5'd7, 32'd9, mul_lat(32'd3));

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
